// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and fault rule for the data-side load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_H  = 3'b001;
  localparam logic [2:0] SEL_W  = 3'b010;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } lsu_state_t;

  // Misalignment, unknown widths and unsigned-store encodings all fault.
  function automatic logic is_fault(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f;
    f = 1'b1;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_BU:   f = we;
      F3_H:    f = addr_lo[0];
      F3_HU:   f = we | addr_lo[0];
      F3_W:    f = (addr_lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: extracts and extends load data, and merges sub-word store
// data into a previously read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {addr, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = word;
    endcase

    merged = word;
    case (funct3)
      F3_B: begin
        case (addr)
          2'd0:    merged[7:0]   = store_data[7:0];
          2'd1:    merged[15:8]  = store_data[7:0];
          2'd2:    merged[23:16] = store_data[7:0];
          default: merged[31:24] = store_data[7:0];
        endcase
      end
      F3_H: begin
        if (addr[1]) merged[31:16] = store_data;
        else         merged[15:0]  = store_data;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into full-word bus
// transfers, using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  lsu_state_t  state, state_n;
  logic        we_q, fault_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wb_data_q, rdata_q;
  logic [15:0] wdata_q;
  logic [31:0] lane_load, lane_merged;
  logic        accept, fault_in;

  assign accept   = (state == S_IDLE) && i_req;
  assign fault_in = is_fault(i_we, i_funct3, i_addr[1:0]);

  lsu_lane u_lane (
    .word       (i_wb_data),
    .addr       (addr_q[1:0]),
    .funct3     (f3_q),
    .store_data (wdata_q),
    .load_data  (lane_load),
    .merged     (lane_merged)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (i_req) begin
          if (fault_in)                      state_n = S_DONE;
          else if (i_we && i_funct3 == F3_W) state_n = S_WR_REQ;
          else                               state_n = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (!i_wb_stall) state_n = S_RD_WAIT;
      S_RD_WAIT: if (i_wb_ack)    state_n = we_q ? S_WR_REQ : S_DONE;
      S_WR_REQ:  if (!i_wb_stall) state_n = S_WR_WAIT;
      S_WR_WAIT: if (i_wb_ack)    state_n = S_DONE;
      S_DONE:                     state_n = S_IDLE;
      default:                    state_n = S_IDLE;
    endcase
  end

  // The read word of a sub-word store becomes the write word after merging.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 16'h0;
      wb_data_q <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q      <= i_we;
        fault_q   <= fault_in;
        f3_q      <= i_funct3;
        addr_q    <= i_addr;
        wdata_q   <= i_wdata[15:0];
        wb_data_q <= i_wdata;
        rdata_q   <= 32'h0;
      end
      if (state == S_RD_WAIT && i_wb_ack) begin
        if (we_q) wb_data_q <= lane_merged;
        else      rdata_q   <= lane_load;
      end
    end
  end

  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_DONE);
  assign o_fault   = o_done && fault_q;
  assign o_rdata   = o_done ? rdata_q : 32'h0;
  assign o_wb_stb  = (state == S_RD_REQ) || (state == S_WR_REQ);
  assign o_wb_we   = (state == S_WR_REQ);
  assign o_wb_addr = {addr_q[31:2], 2'b00};
  assign o_wb_data = wb_data_q;
  assign o_wb_sel  = SEL_W;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-level reference model and
// a word memory that acks two cycles after each strobe.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_busy, o_done, o_fault, o_wb_stb, o_wb_we;
  logic [31:0] o_rdata, o_wb_addr, o_wb_data;
  logic [2:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack, i_wb_stall;

  load_store_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
    .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_data(i_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          nstb;
    int          delta;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ref_bytes [0:255];
  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stb_total = 0;
  int          stb_base = 0;
  logic        extra_stall = 1'b0;
  logic        rand_on = 1'b0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] rd_r = 32'h0;
  logic        hold = 1'b0;
  logic        hold_we = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic [31:0] hold_data = 32'h0;

  assign i_wb_stall = (stall_cnt != 0) || extra_stall;
  assign i_wb_ack   = ack_r;
  assign i_wb_data  = rd_r;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Companion memory: strobe accepted when not stalled, ack two cycles later.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    ack_r <= 1'b0;
    hold <= o_wb_stb && i_wb_stall;
    hold_addr <= o_wb_addr;
    hold_we <= o_wb_we;
    hold_data <= o_wb_data;
    if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    if (pend) begin
      ack_r <= 1'b1;
      pend <= 1'b0;
    end
    if (o_wb_stb && !i_wb_stall) begin
      if (o_wb_we) mem[o_wb_addr[7:2]] = o_wb_data;
      else rd_r <= mem[o_wb_addr[7:2]];
      pend <= 1'b1;
      stall_cnt <= 2;
      stb_total <= stb_total + 1;
    end
  end

  task automatic setWord(input logic [7:0] a, input logic [31:0] v);
    mem[a[7:2]] = v;
    for (int i = 0; i < 4; i++) ref_bytes[{a[7:2], 2'b00} + 8'(i)] = v[8*i +: 8];
  endtask

  // Reference model over a byte array: width, signedness and alignment rules.
  task automatic refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit timed, output exp_t e);
    int nbytes;
    bit sgn;
    logic [31:0] v;
    logic [7:0] a;
    a = addr[7:0];
    nbytes = 0;
    sgn = 1'b0;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: nbytes = 4;
      3'd4: nbytes = 1;
      3'd5: nbytes = 2;
      default: nbytes = 0;
    endcase
    e.acc = 0;
    e.rdata = 32'h0;
    if (nbytes == 0 || (we && f3 >= 3'd4) || (int'(a) % nbytes) != 0) begin
      e.fault = 1'b1;
      e.nstb = 0;
      e.delta = timed ? 0 : -1;
    end else if (we) begin
      e.fault = 1'b0;
      for (int i = 0; i < nbytes; i++) ref_bytes[a + 8'(i)] = wdata[8*i +: 8];
      e.nstb = (nbytes == 4) ? 1 : 2;
      e.delta = !timed ? -1 : (nbytes == 4) ? 3 : 6;
    end else begin
      e.fault = 1'b0;
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_bytes[a + 8'(i)]) << (8 * i));
      if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      e.rdata = v;
      e.nstb = 1;
      e.delta = timed ? 3 : -1;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit timed);
    exp_t e;
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) begin
      checkOutput("busy_timeout", 32'(o_busy), 32'h0);
      return;
    end
    i_req = 1'b1;
    i_we = we;
    i_funct3 = f3;
    i_addr = addr;
    i_wdata = wdata;
    @(posedge i_clk);
    #1;
    refModel(we, f3, addr, wdata, timed, e);
    e.acc = cyc;
    sb_q.push_back(e);
    i_req = 1'b0;
    i_we = $urandom_range(0, 1);
    i_funct3 = 3'($urandom);
    i_addr = $urandom;
    i_wdata = $urandom;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_busy) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (sb_q.size() != 0 || o_busy) checkOutput("drain_timeout", 32'(sb_q.size()), 32'h0);
  endtask

  // Monitor: bus stability under stall and scoreboard comparison on o_done.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset) begin
      stb_base = stb_total;
    end else begin
      if (hold) begin
        checkOutput("stall_hold_stb", 32'(o_wb_stb), 32'h1);
        checkOutput("stall_hold_addr", o_wb_addr, hold_addr);
        checkOutput("stall_hold_we", 32'(o_wb_we), 32'(hold_we));
        checkOutput("stall_hold_data", o_wb_data, hold_data);
      end
      if (o_wb_stb) checkOutput("wb_sel", 32'(o_wb_sel), 32'h2);
      if (o_done) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(o_done), 32'h0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("busy_with_done", 32'(o_busy), 32'h1);
          checkOutput("fault", 32'(o_fault), 32'(e.fault));
          checkOutput("rdata", o_rdata, e.rdata);
          checkOutput("strobes", 32'(stb_total - stb_base), 32'(e.nstb));
          if (e.delta >= 0) checkOutput("latency", 32'(cyc - e.acc), 32'(e.delta));
        end
        stb_base = stb_total;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] f3_list [0:10];
    logic [31:0] ra;
    int n;
    f3_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 64; i++) setWord(8'(4 * i), $urandom);
    setWord(8'h10, 32'h8899AABB);
    setWord(8'h30, 32'h11223344);

    #12;
    checkOutput("reset_ctrl", {27'h0, o_busy, o_done, o_fault, o_wb_stb, o_wb_we}, 32'h0);
    checkOutput("reset_addr", o_wb_addr, 32'h0);
    checkOutput("reset_data", o_wb_data, 32'h0);
    checkOutput("reset_rdata", o_rdata, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    $display("[TB] directed loads");
    applyStimulus(1'b0, 3'd0, 32'h11, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 3'd5, 32'h12, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] word store and read-modify-write");
    applyStimulus(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 3'd0, 32'h32, 32'h123456A5, 1'b1);
    waitDrain();
    checkOutput("mem_0x30", mem[6'h0C], 32'h11A53344);
    applyStimulus(1'b0, 3'd2, 32'h30, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] faults");
    applyStimulus(1'b0, 3'd1, 32'h41, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 3'd2, 32'h42, 32'h55, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 3'd3, 32'h40, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 3'd4, 32'h40, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] stall held during read request");
    extra_stall = 1'b1;
    applyStimulus(1'b0, 3'd1, 32'h12, 32'h0, 1'b0);
    repeat (5) @(negedge i_clk);
    extra_stall = 1'b0;
    waitDrain();

    $display("[TB] reset in read wait");
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    n = 0;
    while (!o_wb_stb && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("reset_test_stb", 32'(o_wb_stb), 32'h1);
    @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("midreset_ctrl", {27'h0, o_busy, o_done, o_fault, o_wb_stb, o_wb_we}, 32'h0);
    checkOutput("midreset_addr", o_wb_addr, 32'h0);
    checkOutput("midreset_data", o_wb_data, 32'h0);
    checkOutput("midreset_rdata", o_rdata, 32'h0);
    sb_q.delete();
    #4;
    i_reset = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      checkOutput("no_done_after_reset", 32'(o_done), 32'h0);
    end
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] random traffic");
    rand_on = 1'b1;
    fork
      begin
        for (int t = 0; t < 80; t++) begin
          ra = {$urandom, 8'($urandom)};
          if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
          applyStimulus(1'($urandom_range(0, 1)), f3_list[$urandom_range(0, 10)], ra, $urandom, 1'b0);
        end
        waitDrain();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge i_clk);
          extra_stall = ($urandom_range(0, 3) == 0);
        end
        extra_stall = 1'b0;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
